// File: rtl/wrr_share_pkg.sv
// Shared types and helpers for the weighted round-robin shared-port arbiter.
package wrr_share_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Advance a requester index by one, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wrr_share_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    int j;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j[IW-1:0]]) begin
                found              = 1'b1;
                idx                = j[IW-1:0];
                onehot[j[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_share_arb.sv
// Weighted round-robin arbiter sharing one valid/ready beat port among N requesters.
module wrr_share_arb
    import wrr_share_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 8,
    parameter  int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            busy,
    output logic            shared_valid,
    output logic [DW-1:0]   shared_data,
    input  logic            shared_ready
);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [WW-1:0] credit;

    logic [IW-1:0] pick_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic          xfer;
    logic          rel;
    logic          load;

    assign busy         = (state == GRANT);
    assign shared_valid = busy & req[gnt_id];
    assign shared_data  = busy ? req_data[int'(gnt_id)*DW +: DW] : '0;
    assign xfer         = shared_valid & shared_ready;
    assign req_ready    = gnt & {N{xfer}};

    // Burst ends on the last credited beat or when the grantee drops its request.
    assign rel  = busy & ((xfer & (credit == '0)) | ~req[gnt_id]);
    assign load = pick_found & (~busy | rel);

    // At a release edge the scan starts just past the grantee, so it wins only when alone.
    assign pick_ptr = busy ? IW'(wrap_inc(int'(gnt_id), N)) : ptr;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            credit <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            if (rel) ptr <= pick_ptr;
            if (load) begin
                state  <= GRANT;
                gnt    <= pick_oh;
                gnt_id <= pick_idx;
                credit <= weight[int'(pick_idx)*WW +: WW];
            end else if (rel) begin
                state <= IDLE;
                gnt   <= '0;
            end else if (xfer && credit != '0) begin
                credit <= credit - 1'b1;
            end
        end
    end

endmodule

// File: doc/wrr_share_arb.md
# wrr_share_arb

Weighted round-robin arbiter that shares one valid/ready datapath port between N requesters, the same one-beat-per-cycle `data` link carried by the team's interface/modport blocks. Each requester receives a burst of up to `weight+1` beats per grant; the arbiter then rotates priority. It sits between the requester-side modports and the single shared consumer.

## Interface
- `N`, 4: number of requesters; 2..16.
- `DW`, 8: data width per beat.
- `WW`, 4: weight width; maximum burst length is 2^WW beats.
- `IW`, `$clog2(N)`: derived localparam, grant index width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request, level.
- `req_data`  in  N*DW  per-requester beat data; slice i belongs to requester i.
- `weight`  in  N*WW  per-requester burst weight; sampled only at the grant edge.
- `req_ready`  out  N  beat accepted from requester i this cycle.
- `gnt`  out  N  registered one-hot grant.
- `gnt_id`  out  IW  index of the current grantee; valid while `busy`.
- `busy`  out  1  a grant is active.
- `shared_valid`  out  1  beat offered to the consumer.
- `shared_data`  out  DW  beat data.
- `shared_ready`  in  1  consumer accepts.

## Operation
- States: `IDLE` and `GRANT`.
- `IDLE`: when any `req` bit is high, pick the winner by round-robin starting at `ptr`. Next edge: `GRANT`, `gnt`/`gnt_id` set to the winner, `credit <= weight[winner]`.
- `GRANT`:
  - `shared_valid = req[gnt_id]` (combinational).
  - `shared_data = req_data[gnt_id]`.
  - `req_ready = gnt & {N{shared_ready & shared_valid}}`.
- A transfer is `shared_valid & shared_ready`.
  - Each transfer with `credit != 0` decrements `credit`.
- Release at the edge when either:
  - a transfer occurs with `credit == 0`, or
  - `req[gnt_id]` is low.
- On release, `ptr <= gnt_id + 1`, wrapping from N-1 to 0.
  - If any other `req` is high at the release edge, re-arbitrate in the same cycle with the new pointer and grant directly. There is no idle bubble. `credit` reloads from the new winner's weight.
  - Otherwise go to `IDLE` with `gnt = 0`.
- The releasing requester is lowest priority in the release-edge arbitration. It may win only if it is the sole requester.
- The round-robin picker selects the first set bit of `req` at or after `ptr`, scanning upward with wrap.
- Weight 0 gives a 1-beat burst. Weight 2^WW−1 gives a 2^WW-beat burst.
- `weight` changes during a grant have no effect until the next grant.
- Consumer back-pressure (`shared_ready` low) stalls the burst. `credit` is unchanged and the grant is held indefinitely while `req` stays high.
- Requester contract: `req_data` stable while `req & gnt & ~shared_ready`.

## Timing
- Reset (async assert, sync release) sets:
  - state `IDLE`, `ptr = 0`, `credit = 0`.
  - `gnt = 0`, `gnt_id = 0`, `busy = 0`.
  - `shared_valid = 0`, `req_ready = 0`, `shared_data = 0`.
- Reset mid-burst aborts immediately. No beat is reported as transferred in the reset cycle.
- Request-to-grant latency from `IDLE` is 1 cycle. The first beat can transfer in the cycle `gnt` rises.
- Back-to-back grant switch: the last beat of A and the first beat of B are on consecutive cycles.
- Steady-state throughput is 1 beat/cycle. The only bubble is a requester dropping `req`, which costs 1 cycle.
- `gnt`, `gnt_id`, `busy`, `credit` and `ptr` are registered.
- `shared_valid`, `shared_data` and `req_ready` are combinational from the registers, `req`, `req_data` and `shared_ready`.

## Structure
- Package `wrr_share_pkg`:
  - `state_t` enum {`IDLE`, `GRANT`}.
  - Helper function `wrap_inc(idx, n)`.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `req[N]`, `ptr[IW]`.
  - Outputs: `found`, `idx[IW]`, `onehot[N]`.
  - Instantiated once.
- Top: state register, credit counter, pointer, output muxes.

## Test plan
- Single requester: `req=4'b0001`, `weight0=3`, `shared_ready=1` → `gnt=0001` one cycle after `req`, exactly 4 transfers, then release. Re-grant follows on the next edge because it is the sole requester.
- All four requesting, weights {1,0,2,0}, `ready=1` → grant order 0,1,2,3,0…; bursts of 2,1,3,1 beats; no idle cycle between grants.
- Back-pressure: requester 2, `weight=2`; toggle `shared_ready` 1,0,0,1,1 → exactly 3 transfers; `credit` frozen while ready is low; release after the 3rd transfer.
- Early drop: requester 1, `weight=7`; drop `req[1]` after 2 beats while `req[3]` high → requester 3 is granted at the next edge; `ptr` becomes 2.
- Weight change mid-burst: `weight0` changes 5→0 after the grant → the burst is still 6 beats; the next grant uses 0 (1 beat).
- Reset mid-burst: assert `rst_n=0` during beat 2 of 4 → all outputs 0 immediately. After release with `req=4'b0110`, requester 1 is granted (`ptr=0`).
